// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART TX write port between
// byte-stream requesters, with a per-message gap watchdog.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_full,
  output logic                          abort,
  output logic [$clog2(N_REQ)-1:0]      abort_id
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  state, state_nxt;
  logic [N_REQ-1:0]        grant_nxt;
  logic                    busy_nxt;
  logic                    tx_valid_nxt;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;
  logic                    abort_nxt;
  logic [ID_W-1:0]         abort_id_nxt;
  // last_id doubles as the owner index while a message is in progress
  logic [ID_W-1:0]         last_id, last_id_nxt;
  logic [GAP_W-1:0]        gap_cnt, gap_cnt_nxt;
  logic                    win_found;
  logic [ID_W-1:0]         win_id;
  logic                    own_valid;
  logic                    own_last;
  logic                    gap_hit;
  logic                    xfer;

  // Round-robin winner: first valid requester after last_id, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      if (!win_found && req_valid[ID_W'((32'(last_id) + off) % N_REQ)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((32'(last_id) + off) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    busy_nxt     = busy;
    tx_valid_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    abort_nxt    = 1'b0;
    abort_id_nxt = abort_id;
    last_id_nxt  = last_id;
    gap_cnt_nxt  = gap_cnt;
    req_ready    = '0;

    own_valid = req_valid[last_id];
    own_last  = req_last[last_id];
    gap_hit   = (gap_cnt == GAP_W'(GAP_TIMEOUT));
    // One byte per two cycles: a pending write strobe blocks the next transfer
    xfer      = (state == S_BUSY) && own_valid && !tx_full && !tx_valid && !gap_hit;

    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt   = S_BUSY;
          grant_nxt   = N_REQ'(1) << win_id;
          busy_nxt    = 1'b1;
          last_id_nxt = win_id;
          gap_cnt_nxt = '0;
        end
      end
      S_BUSY: begin
        req_ready[last_id] = xfer;
        if (gap_hit) begin
          state_nxt    = S_IDLE;
          grant_nxt    = '0;
          busy_nxt     = 1'b0;
          abort_nxt    = 1'b1;
          abort_id_nxt = last_id;
        end else if (xfer) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = req_data[32'(last_id)*DATA_WIDTH +: DATA_WIDTH];
          gap_cnt_nxt  = '0;
          if (own_last) begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
          end
        end else if (!own_valid) begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      abort    <= 1'b0;
      abort_id <= '0;
      last_id  <= ID_W'(N_REQ - 1);
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      abort    <= abort_nxt;
      abort_id <= abort_id_nxt;
      last_id  <= last_id_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: lane byte queues drive requesters, an
// expected-byte scoreboard checks tx_data order, and directed checks cover timing.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned GT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_full;
  logic            abort;
  logic [1:0]      abort_id;

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .GAP_TIMEOUT(GT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_full(tx_full),
    .abort(abort), .abort_id(abort_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  logic [1:0]  abort_id_seen;
  logic [N-1:0] prev_grant = '0;
  logic [8:0]  lane_q [N][$];
  logic [7:0]  exp_q [$];
  int          tx_times [$];
  logic [N-1:0] gr_q [$];
  int          gr_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = lane_q[i].size() > 0;
      req_data[i*DW +: DW] = req_valid[i] ? lane_q[i][0][7:0] : 8'h00;
      req_last[i]          = req_valid[i] ? lane_q[i][0][8] : 1'b0;
    end
  endfunction

  // Observe the current cycle at negedge, then advance one clock and re-drive
  task automatic step();
    logic [N-1:0] xf;
    @(negedge clk);
    if (tx_valid === 1'b1) begin
      tx_times.push_back(cyc);
      if (exp_q.size() == 0) chk("tx_extra", 32'(tx_valid), 32'd0);
      else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (abort === 1'b1) begin
      abort_cnt++;
      abort_cyc     = cyc;
      abort_id_seen = abort_id;
    end
    if (grant !== '0 && grant !== prev_grant) begin
      gr_q.push_back(grant);
      gr_cyc.push_back(cyc);
    end
    prev_grant = grant;
    xf = req_valid & req_ready;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (xf[i]) void'(lane_q[i].pop_front());
    drive();
  endtask

  task automatic push_msg(input int lane, input logic [7:0] first, input int len);
    for (int j = 0; j < len; j++) begin
      lane_q[lane].push_back({(j == len - 1), 8'(first + 8'(j))});
      exp_q.push_back(8'(first + 8'(j)));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (exp_q.size() > 0); n++) step();
    step();
    step();
  endtask

  initial begin
    int t0;
    rst_n   = 1'b0;
    tx_full = 1'b0;
    drive();
    step();
    step();
    // Reset values
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_abort_id", 32'(abort_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Single message on requester 1
    tx_times.delete();
    push_msg(1, 8'h41, 3);
    drive();
    t0 = cyc;
    step();
    chk("single_grant", 32'(grant), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 40 && lane_q[1].size() > 0; n++) step();
    chk("single_end_grant", 32'(grant), 32'd0);
    chk("single_end_busy", 32'(busy), 32'd0);
    drain(20);
    chk("single_tx_count", 32'(tx_times.size()), 32'd3);
    if (tx_times.size() >= 3) begin
      chk("single_first_lat", 32'(tx_times[0] - t0), 32'd2);
      chk("single_gap1", 32'(tx_times[1] - tx_times[0]), 32'd2);
      chk("single_gap2", 32'(tx_times[2] - tx_times[1]), 32'd2);
    end

    // Round robin after a fresh reset
    do_reset();
    gr_q.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_msg(i, 8'(8'hA0 + 8'(i)), 1);
    drive();
    drain(60);
    chk("rr_grant_count", 32'(gr_q.size()), 32'd6);
    if (gr_q.size() >= 5) begin
      chk("rr_g0", 32'(gr_q[0]), 32'd1);
      chk("rr_g1", 32'(gr_q[1]), 32'd2);
      chk("rr_g2", 32'(gr_q[2]), 32'd4);
      chk("rr_g3", 32'(gr_q[3]), 32'd1);
      chk("rr_g4", 32'(gr_q[4]), 32'd2);
    end

    // Back-pressure longer than the watchdog limit must not abort
    tx_times.delete();
    push_msg(0, 8'h10, 5);
    drive();
    for (int n = 0; n < 30 && tx_times.size() < 2; n++) step();
    chk("bp_prefix", 32'(tx_times.size()), 32'd2);
    tx_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_tx_valid", 32'(tx_valid), 32'd0);
      chk("bp_abort", 32'(abort), 32'd0);
    end
    tx_full = 1'b0;
    drain(40);
    chk("bp_complete", 32'(exp_q.size()), 32'd0);
    chk("bp_no_abort", 32'(abort_cnt), 32'd0);

    // Watchdog: owner 2 stalls after one byte while requester 0 waits
    tx_times.delete();
    gr_q.delete();
    gr_cyc.delete();
    lane_q[2].push_back({1'b0, 8'hB0});
    exp_q.push_back(8'hB0);
    push_msg(0, 8'hC0, 1);
    drive();
    for (int n = 0; n < 40 && abort_cnt == 0; n++) step();
    chk("wd_abort_seen", 32'(abort_cnt), 32'd1);
    chk("wd_first_owner", 32'(gr_q.size() > 0 ? gr_q[0] : 3'd0), 32'd4);
    if (tx_times.size() > 0)
      chk("wd_abort_delay", 32'(abort_cyc - tx_times[0]), 32'd9);
    chk("wd_abort_id", 32'(abort_id_seen), 32'd2);
    drain(30);
    chk("wd_regrant_count", 32'(gr_q.size()), 32'd2);
    if (gr_q.size() >= 2) begin
      chk("wd_regrant", 32'(gr_q[1]), 32'd1);
      chk("wd_regrant_cyc", 32'(gr_cyc[1] - abort_cyc), 32'd1);
    end
    chk("wd_single_pulse", 32'(abort_cnt), 32'd1);
    chk("wd_id_held", 32'(abort_id), 32'd2);

    // Non-owner isolation: 0xFF from requester 2 waits behind requester 0
    push_msg(0, 8'hD0, 4);
    drive();
    step();
    push_msg(2, 8'hFF, 1);
    drive();
    drain(60);
    chk("iso_complete", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a message
    tx_times.delete();
    lane_q[1].push_back({1'b0, 8'hE0});
    lane_q[1].push_back({1'b0, 8'hE1});
    lane_q[1].push_back({1'b0, 8'hE2});
    lane_q[1].push_back({1'b1, 8'hE3});
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE1);
    drive();
    for (int n = 0; n < 30 && tx_times.size() < 2; n++) step();
    lane_q[1].delete();
    drive();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_abort", 32'(abort), 32'd0);
    chk("mid_rst_abort_id", 32'(abort_id), 32'd0);
    gr_q.delete();
    push_msg(0, 8'hF0, 1);
    push_msg(1, 8'hF1, 1);
    drive();
    drain(30);
    chk("post_rst_first", 32'(gr_q.size() > 0 ? gr_q[0] : 3'd0), 32'd1);
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);
    chk("no_extra_abort", 32'(abort_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
